// File: rtl/instruction_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instruction_encoder                                           |
// | Purpose  : Packs decoded RV32 fields into instruction words behind a     |
// |            2-entry output FIFO; optional ENCODER_RANGE_CHECK_EN macro    |
// |            enables immediate range / format error flagging.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instruction_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam logic [2:0] c_fmt_r = 3'd0;
  localparam logic [2:0] c_fmt_i = 3'd1;
  localparam logic [2:0] c_fmt_s = 3'd2;
  localparam logic [2:0] c_fmt_b = 3'd3;
  localparam logic [2:0] c_fmt_u = 3'd4;
  localparam logic [2:0] c_fmt_j = 3'd5;
  localparam logic [1:0] c_full  = FIFO_DEPTH[1:0];

  logic [31:0] w_word;
  logic        w_err;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_nxt;

  logic [1:0]  r_count;
  logic [31:0] r_head_word;
  logic        r_head_err;
  logic [31:0] r_tail_word;
  logic        r_tail_err;
  logic        r_out_valid;
  logic        r_in_ready;
  logic [15:0] r_enc_count;
  logic [7:0]  r_err_count;

  always_comb begin
    w_word = 32'h0000_0000;
    case (fmt)
      c_fmt_r: w_word = {funct7, rs2, rs1, funct3, rd, opcode};
      c_fmt_i: w_word = {imm[11:0], rs1, funct3, rd, opcode};
      c_fmt_s: w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      c_fmt_b: w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      c_fmt_u: w_word = {imm[31:12], rd, opcode};
      c_fmt_j: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_word = 32'h0000_0000;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // A value fits in N signed bits when bits [31:N-1] are all equal.
  logic w_fits12;
  logic w_fits13;
  logic w_fits21;
  assign w_fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign w_fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    w_err = 1'b0;
    case (fmt)
      c_fmt_r: w_err = 1'b0;
      c_fmt_i: w_err = ~w_fits12;
      c_fmt_s: w_err = ~w_fits12;
      c_fmt_b: w_err = ~w_fits13 | imm[0];
      c_fmt_u: w_err = |imm[11:0];
      c_fmt_j: w_err = ~w_fits21 | imm[0];
      default: w_err = 1'b1;
    endcase
  end
`else
  assign w_err = 1'b0;
`endif

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= 2'd0;
      r_head_word <= 32'h0000_0000;
      r_head_err  <= 1'b0;
      r_tail_word <= 32'h0000_0000;
      r_tail_err  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_enc_count <= 16'd0;
      r_err_count <= 8'd0;
    end else begin
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != 2'd0);
      r_in_ready  <= (w_count_nxt != c_full);

      // Head is the output register; tail only holds the second entry.
      if (w_pop) begin
        if (r_count == c_full) begin
          r_head_word <= r_tail_word;
          r_head_err  <= r_tail_err;
        end else if (w_push) begin
          r_head_word <= w_word;
          r_head_err  <= w_err;
        end
      end else if (w_push && r_count == 2'd0) begin
        r_head_word <= w_word;
        r_head_err  <= w_err;
      end

      if (w_push && !w_pop && r_count == 2'd1) begin
        r_tail_word <= w_word;
        r_tail_err  <= w_err;
      end

      if (w_push) begin
        r_enc_count <= r_enc_count + 16'd1;
        if (w_err && r_err_count != 8'hFF)
          r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign instr     = r_head_word;
  assign out_err   = r_head_err;
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/instruction_encoder.md
# instruction_encoder

Streaming RV32-format instruction encoder: accepts decoded fields (format, opcode, registers, functs, full 32-bit immediate) and packs them into a 32-bit instruction word. It is the inverse of the core's immediate extraction path, scattering immediate bits into the format-specific instruction positions. It feeds the program-loader/self-test path that writes generated code into instruction memory. It contains a 2-entry output FIFO with valid/ready handshakes on both sides, immediate range checking, and status counters.

## Interface
Parameters:
- FIFO_DEPTH, 2: output buffer entries; only 2 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept; equals (fifo count != 2)
- fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are invalid
- opcode  input  7  placed at [6:0]
- rd, rs1, rs2  input  5 each  register fields
- funct3  input  3  placed at [14:12]
- funct7  input  7  R-format only, placed at [31:25]
- imm  input  32  signed byte-offset or value
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- instr  output  32  encoded word at FIFO head
- out_err  output  1  range/format error flag for the head word
- enc_count  output  16  accepted bundles, wraps from 0xFFFF to 0
- err_count  output  8  accepted bundles with error, saturates at 255

## Operation
- Accept when in_valid && in_ready. Encoding is combinational from the inputs. The word and its error flag are written to the FIFO tail on the same edge.
- Bit placement:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7.
  - U: imm[31:12]→[31:12].
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12].
- Unused fields are ignored. rs1/rs2/rd/funct3 are placed only where the format defines them.
- Range rules (error when violated):
  - I/S: imm within signed 12-bit.
  - B: signed 13-bit and imm[0]=0.
  - J: signed 21-bit and imm[0]=0.
  - U: imm[11:0]=0.
  - R: never errors.
- On a range error, instr holds the truncated encoding and out_err=1.
- Invalid fmt: instr=0x00000000, out_err=1.
- FIFO control:
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - While full, in_ready=0 even if out_ready=1 that cycle; no combinational ready path.
- Counters update on accept: enc_count +1; err_count +1 if the error flag is set (saturating).

## Timing
- Latency: accept at edge N → out_valid=1 with that word after edge N, i.e. visible in cycle N+1.
- Throughput: 1 word/cycle when out_ready is held high.
- in_ready, out_valid, instr and out_err are driven from registers only.
- Reset (including mid-transfer): FIFO emptied. out_valid=0, in_ready=1, instr=0, out_err=0, enc_count=0, err_count=0. In-flight words are discarded.
- A held out_valid word must not change until popped.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: range rules and invalid-fmt detection are active, as described above.
- Not defined:
  - Range checking is removed.
  - Immediates are silently truncated.
  - out_err is tied to 0 and err_count stays 0.
  - Invalid fmt still produces instr=0.

## Test plan
- I-format: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 → instr=0x00500093, out_err=0, one cycle after accept.
- S-format: fmt=2, opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 → 0x0020A423. B-format: fmt=3, opcode=0x63, rs1=rs2=0, imm=−4 → 0xFE000EE3.
- Range error (macro on): fmt=1, imm=2048 → out_err=1, err_count=1. Repeat with fmt=3, imm=6 (odd halfword OK) and imm=7 → out_err=0 then 1. Macro off: out_err=0 and err_count=0.
- Backpressure:
  - Hold out_ready=0 and present 3 bundles.
  - Expect in_ready=0 after 2 accepts and enc_count=2.
  - Raise out_ready: words emerge in order, then the 3rd is accepted.
- Back-to-back streaming: out_ready=1 with in_valid high for 20 cycles → 20 words on consecutive cycles, enc_count=20. Simultaneous push/pop keeps count at 1.
- Reset with FIFO full: assert rst for one cycle → out_valid=0, in_ready=1, counters 0 on the next cycle. The next accepted word appears alone, one cycle later.
